// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle-stage monitor: FSM encoding and
// default sizing.
package toggle_pkg;

    localparam int unsigned WIDTH_DEFAULT   = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2,
        STALL  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus history flop; flags any change of the
// synchronized level as an edge.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic edge_c,
    output logic level
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign edge_c = s2 ^ s3;
    assign level  = s2;

endmodule

// File: rtl/toggle_monitor.sv
// Measures the edge-to-edge interval of an asynchronous toggle signal,
// reports lock on two equal periods and a stall after a long idle gap.
module toggle_monitor #(
    parameter int unsigned WIDTH   = toggle_pkg::WIDTH_DEFAULT,
    parameter int unsigned TIMEOUT = toggle_pkg::TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             t_in,
    input  logic             clear,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic [WIDTH-1:0] edge_count,
    output logic             locked,
    output logic             stalled
);
    import toggle_pkg::*;

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] STALL_AT = WIDTH'(TIMEOUT - 1);

    logic [1:0]       rst_pipe;
    logic             rst_n;
    logic             edge_c;
    logic             level_unused;
    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] meas_c;
    logic             prev_valid;
    logic             prev_valid_next;
    logic             load_c;
    logic             timeout_c;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_n = rst_pipe[1];

    sync_edge u_sync (
        .clk    (clk),
        .reset  (rst_n),
        .d      (t_in),
        .edge_c (edge_c),
        .level  (level_unused)
    );

    // Saturating cnt+1 doubles as the measured interval and the counter increment.
    assign meas_c    = (cnt == CNT_MAX) ? CNT_MAX : cnt + WIDTH'(1);
    assign timeout_c = (cnt >= STALL_AT);

    always_comb begin
        state_next      = state;
        prev_valid_next = prev_valid;
        load_c          = 1'b0;
        if (clear) begin
            state_next      = IDLE;
            prev_valid_next = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (edge_c) state_next = ARMED;
                end
                ARMED: begin
                    if (edge_c) begin
                        load_c          = 1'b1;
                        prev_valid_next = 1'b1;
                        if (prev_valid && (meas_c == period)) state_next = LOCKED;
                    end else if (timeout_c) begin
                        state_next = STALL;
                    end
                end
                LOCKED: begin
                    if (edge_c) begin
                        load_c          = 1'b1;
                        prev_valid_next = 1'b1;
                        if (meas_c != period) state_next = ARMED;
                    end else if (timeout_c) begin
                        state_next = STALL;
                    end
                end
                STALL: begin
                    // Interval spanning the stall is meaningless; restart the pairing.
                    if (edge_c) begin
                        state_next      = ARMED;
                        prev_valid_next = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prev_valid   <= 1'b0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            edge_count   <= '0;
            locked       <= 1'b0;
            stalled      <= 1'b0;
        end else begin
            state        <= state_next;
            prev_valid   <= prev_valid_next;
            period_valid <= load_c;
            locked       <= (state_next == LOCKED);
            stalled      <= (state_next == STALL);
            if (clear) begin
                cnt        <= '0;
                period     <= '0;
                edge_count <= '0;
            end else begin
                cnt        <= edge_c ? '0 : meas_c;
                edge_count <= edge_count + WIDTH'(edge_c);
                if (load_c) period <= meas_c;
            end
        end
    end

endmodule
